// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single memory port: arbitrates, registers the winning access,
// strobes the memory once and acks the owner, returning read data on the ack cycle.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned PRIO0  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] adr0,
   input  logic [DATA_W-1:0] wd0,
   output logic              gnt0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] adr1,
   input  logic [DATA_W-1:0] wd1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

   state_t              r_state;
   logic                r_gnt0;
   logic                r_gnt1;
   logic                r_ack0;
   logic                r_ack1;
   logic                r_rr;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_adr;
   logic [DATA_W-1:0]   r_mem_wd;
   logic [DATA_W-1:0]   r_rdata;
   logic [2:0]          r_cnt;

   logic                w_any;
   logic                w_pick1;
   logic                w_in_ack;
   logic                w_rd_ack;

   assign w_any    = req0 | req1;
   // On a tie, round-robin picks the port that did not win last time.
   assign w_pick1  = (PRIO0 != 0) ? (req1 & ~req0) : (req1 & (~req0 | ~r_rr));
   assign w_in_ack = r_ack0 | r_ack1;
   assign w_rd_ack = w_in_ack & ~r_mem_we;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= StIdle;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_rr      <= 1'b1;
         r_mem_en  <= 1'b0;
         r_mem_we  <= 1'b0;
         r_mem_adr <= '0;
         r_mem_wd  <= '0;
         r_rdata   <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               r_ack0   <= 1'b0;
               r_ack1   <= 1'b0;
               r_gnt0   <= 1'b0;
               r_gnt1   <= 1'b0;
               r_mem_en <= 1'b0;
               if (w_rd_ack) begin
                  r_rdata <= mem_rd;
               end
               // The ack cycle itself never arbitrates, so gnt drops for at least one cycle.
               if (!w_in_ack && w_any) begin
                  r_gnt0    <= ~w_pick1;
                  r_gnt1    <= w_pick1;
                  r_rr      <= w_pick1;
                  r_mem_we  <= w_pick1 ? we1  : we0;
                  r_mem_adr <= w_pick1 ? adr1 : adr0;
                  r_mem_wd  <= w_pick1 ? wd1  : wd0;
                  r_state   <= StIssue;
               end
            end
            StIssue: begin
               r_mem_en <= 1'b1;
               if (r_mem_we) begin
                  r_ack0  <= r_gnt0;
                  r_ack1  <= r_gnt1;
                  r_state <= StIdle;
               end else begin
                  r_cnt   <= 3'(RD_LAT);
                  r_state <= StWait;
               end
            end
            StWait: begin
               r_mem_en <= 1'b0;
               if (r_cnt == 3'd1) begin
                  r_ack0  <= r_gnt0;
                  r_ack1  <= r_gnt1;
                  r_state <= StIdle;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign ack0    = r_ack0;
   assign ack1    = r_ack1;
   assign mem_en  = r_mem_en;
   assign mem_we  = r_mem_we;
   assign mem_adr = r_mem_adr;
   assign mem_wd  = r_mem_wd;
   // mem_rd is valid during the read ack cycle; the registered copy holds it afterwards.
   assign rdata   = w_rd_ack ? mem_rd : r_rdata;

endmodule
